mdu_iterative: RTL and testbench

Iterative multiply/divide unit for the MIPS32 core, serving MULT, MULTU, DIV, DIVU, MTHI and MTLO, the operations the single-cycle ALU does not execute. The core issues a request with operands and an opcode. The unit owns the architectural HI/LO registers, computes over 32 iteration cycles and signals completion with a one-cycle `done` pulse. It sits beside the ALU in the execute stage; the core stalls on `busy` before MFHI/MFLO or a new request.

---
 rtl/mdu_iterative.sv | 133 +++++++++++++
 tb/tb_mdu_iterative.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mdu_iterative.sv
// Iterative MIPS32 multiply/divide unit owning HI/LO.
// Shift-add multiply and restoring divide, 32 iterations plus a fix-up cycle.
module mdu_iterative #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      md_op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            mthi,
  input  logic            mtlo,
  output logic            busy,
  output logic            done,
  output logic            div_by_zero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } state_t;

  state_t            state;
  logic [5:0]        cnt;
  logic              is_div;
  logic              dz;
  logic              neg_q;
  logic              neg_r;
  logic [XLEN-1:0]   a_raw;
  logic [XLEN-1:0]   opb;
  logic [XLEN-1:0]   quo;
  logic [XLEN:0]     rem;
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] mcand;

  logic              sgn;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic [XLEN:0]     rem_sh;
  logic [XLEN+1:0]   diff;
  logic [XLEN-1:0]   rem_lo;

  // Operand magnitudes and one restoring-divide step.
  assign sgn    = ~md_op[0];
  assign mag_a  = (sgn && a[XLEN-1]) ? (~a + 1'b1) : a;
  assign mag_b  = (sgn && b[XLEN-1]) ? (~b + 1'b1) : b;
  assign rem_sh = {rem[XLEN-1:0], quo[XLEN-1]};
  assign diff   = {1'b0, rem_sh} - {2'b00, opb};
  assign rem_lo = rem[XLEN-1:0];

  // Control FSM with registered datapath and outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      is_div      <= 1'b0;
      dz          <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      a_raw       <= '0;
      opb         <= '0;
      quo         <= '0;
      rem         <= '0;
      prod        <= '0;
      mcand       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            is_div <= md_op[1];
            dz     <= md_op[1] && (b == '0);
            neg_q  <= sgn & (a[XLEN-1] ^ b[XLEN-1]);
            neg_r  <= sgn & a[XLEN-1];
            a_raw  <= a;
            opb    <= mag_b;
            quo    <= mag_a;
            rem    <= '0;
            prod   <= '0;
            mcand  <= {{XLEN{1'b0}}, mag_a};
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= CALC;
          end else begin
            if (mthi) hi <= a;
            if (mtlo) lo <= a;
          end
        end
        CALC: begin
          if (is_div) begin
            rem <= diff[XLEN+1] ? rem_sh : diff[XLEN:0];
            quo <= {quo[XLEN-2:0], ~diff[XLEN+1]};
          end else begin
            if (opb[0]) prod <= prod + mcand;
            mcand <= mcand << 1;
            opb   <= opb >> 1;
          end
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) state <= FIN;
        end
        FIN: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
          if (is_div) begin
            if (dz) begin
              hi          <= a_raw;
              lo          <= '1;
              div_by_zero <= 1'b1;
            end else begin
              lo <= neg_q ? (~quo + 1'b1) : quo;
              hi <= neg_r ? (~rem_lo + 1'b1) : rem_lo;
            end
          end else begin
            {hi, lo} <= neg_q ? (~prod + 1'b1) : prod;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iterative.sv
// Scoreboard bench for mdu_iterative.
// Directed vectors; a monitor compares each done against queued results.
module tb_mdu_iterative;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  md_op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int fails  = 0;
  logic [64:0] sb[$];

  localparam logic [1:0] MULT  = 2'b00;
  localparam logic [1:0] MULTU = 2'b01;
  localparam logic [1:0] DIV   = 2'b10;
  localparam logic [1:0] DIVU  = 2'b11;

  mdu_iterative #(.XLEN(32)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .md_op(md_op),
    .a(a),
    .b(b),
    .mthi(mthi),
    .mtlo(mtlo),
    .busy(busy),
    .done(done),
    .div_by_zero(div_by_zero),
    .hi(hi),
    .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [64:0] act,
                     input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued result.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_done: got hi=%h lo=%h want none", hi, lo);
      end else begin
        chk("result", {div_by_zero, hi, lo}, sb.pop_front());
        chk("busy_at_done", {64'd0, busy}, 65'd0);
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] eh,
                       input logic [31:0] el, input logic ez);
    @(negedge clk);
    start = 1'b1;
    md_op = op;
    a = x;
    b = y;
    sb.push_back({ez, eh, el});
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    md_op = 2'($urandom);
  endtask

  task automatic wait_done(input string nm, input int skipped);
    int nb = skipped;
    int t = 0;
    while (!done && t < 60) begin
      @(negedge clk);
      t++;
      if (busy) nb++;
    end
    chk({nm, "_timeout"}, {64'd0, done}, 65'd1);
    chk({nm, "_latency"}, 65'(nb + 1), 65'd34);
    @(negedge clk);
    chk({nm, "_done_width"}, {64'd0, done}, 65'd0);
  endtask

  initial begin
    #12;
    chk("reset_state", {busy, done, div_by_zero, hi, lo}, 67'd0);
    @(negedge clk);
    rst = 1'b0;

    issue(MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    wait_done("mult_neg", 0);
    issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 1'b0);
    wait_done("multu_max", 0);
    issue(MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 1'b0);
    wait_done("mult_m1", 0);
    issue(DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    wait_done("div_neg", 0);
    issue(DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    wait_done("divu", 0);
    issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
    wait_done("div_ovf", 0);
    issue(DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b1);
    wait_done("divu_dz", 0);
    issue(DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    wait_done("divu_after_dz", 0);
    issue(DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);
    wait_done("div_dz", 0);

    // MTHI alone, then MTHI+MTLO together.
    @(negedge clk);
    mthi = 1'b1;
    a = 32'h1234_5678;
    @(negedge clk);
    mthi = 1'b0;
    chk("mthi", {33'd0, hi}, {33'd0, 32'h1234_5678});
    chk("mthi_no_done", {64'd0, done}, 65'd0);
    mthi = 1'b1;
    mtlo = 1'b1;
    a = 32'hAAAA_5555;
    @(negedge clk);
    mthi = 1'b0;
    mtlo = 1'b0;
    chk("mthi_mtlo", {1'b0, hi, lo}, {1'b0, 32'hAAAA_5555, 32'hAAAA_5555});

    // start together with mtlo: move ignored, HI/LO frozen in CALC.
    @(negedge clk);
    start = 1'b1;
    mtlo = 1'b1;
    md_op = MULTU;
    a = 32'd2;
    b = 32'd3;
    sb.push_back({1'b0, 32'd0, 32'd6});
    @(posedge clk);
    #1;
    start = 1'b0;
    mtlo = 1'b0;
    @(negedge clk);
    chk("start_mtlo_hold", {1'b0, hi, lo},
        {1'b0, 32'hAAAA_5555, 32'hAAAA_5555});
    wait_done("start_mtlo", 1);

    // mtlo and a second start while busy are both ignored.
    issue(MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0);
    repeat (5) @(negedge clk);
    start = 1'b1;
    mtlo = 1'b1;
    md_op = MULTU;
    a = 32'hDEAD_BEEF;
    b = 32'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    mtlo = 1'b0;
    wait_done("busy_ignore", 5);
    repeat (40) @(negedge clk);

    // Reset mid-operation aborts with no done.
    issue(MULTU, 32'd1234, 32'd5678, 32'd0, 32'd0, 1'b0);
    repeat (11) @(negedge clk);
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    chk("async_reset", {busy, done, div_by_zero, hi, lo}, 67'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    issue(MULTU, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 1'b0);
    wait_done("after_reset", 0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 65'(sb.size()), 65'd0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
